// File: rtl/subterranean_hash_sequencer.sv
// Command sequencer that runs an unkeyed Subterranean hash (init, absorb, blank, squeeze) on a duplex core.
// Optional cycle counter output enabled by defining SUBTERRANEAN_SEQ_PERF_CNT_EN.
module subterranean_hash_sequencer #(
  parameter int DIGEST_WORDS = 8,
  parameter int BLANK_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  input  logic        msg_last,
  input  logic [2:0]  msg_size,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        core_start_operation,
  output logic [3:0]  core_operation_type,
  output logic [31:0] core_buffer_in,
  output logic [1:0]  core_buffer_in_size,
  input  logic [31:0] core_buffer_out,
  input  logic        core_free,
  input  logic        core_finish
`ifdef SUBTERRANEAN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam logic [3:0]  OP_INIT    = 4'd0;
  localparam logic [3:0]  OP_FULL    = 4'd1;
  localparam logic [3:0]  OP_PART    = 4'd2;
  localparam logic [3:0]  OP_SQZ     = 4'd7;
  localparam logic [31:0] PAD_WORD   = 32'h0000_0001;
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK_ROUNDS - 1);
  localparam logic [7:0]  DIG_LAST   = 8'(DIGEST_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_ABS_WAIT,
    S_ABS_BLK_ISSUE,
    S_ABS_BLK_WAIT,
    S_ABS_EMPTY_ISSUE,
    S_ABS_EMPTY_WAIT,
    S_BLANK_ISSUE,
    S_BLANK_WAIT,
    S_SQZ_ISSUE,
    S_SQZ_WAIT,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  size_q, size_d;
  logic        last_q, last_d;
  logic        pad_q, pad_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] dig_data_q, dig_data_d;
  logic        dig_last_q, dig_last_d;

  // Keep n valid bytes, append the 1 pad bit right above them, clear everything higher.
  function automatic logic [31:0] pad_block(input logic [31:0] data, input logic [2:0] size);
    case (size)
      3'd0:    return PAD_WORD;
      3'd1:    return {23'h0, 1'b1, data[7:0]};
      3'd2:    return {15'h0, 1'b1, data[15:0]};
      3'd3:    return {7'h0, 1'b1, data[23:0]};
      default: return data;
    endcase
  endfunction

  always_comb begin
    state_d              = state_q;
    op_d                 = op_q;
    buf_d                = buf_q;
    size_d               = size_q;
    last_d               = last_q;
    pad_d                = pad_q;
    cnt_d                = cnt_q;
    dig_data_d           = dig_data_q;
    dig_last_d           = dig_last_q;
    msg_ready            = 1'b0;
    core_start_operation = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          state_d = S_INIT_ISSUE;
          op_d    = OP_INIT;
          buf_d   = 32'h0;
          size_d  = 2'd0;
          cnt_d   = 8'd0;
          last_d  = 1'b0;
          pad_d   = 1'b0;
        end
      end
      S_INIT_ISSUE: begin
        if (core_free) begin
          core_start_operation = 1'b1;
          state_d              = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: begin
        if (core_finish) state_d = S_ABS_WAIT;
      end
      S_ABS_WAIT: begin
        msg_ready = core_free;
        if (core_free && msg_valid) begin
          op_d    = (msg_size == 3'd4) ? OP_FULL : OP_PART;
          buf_d   = pad_block(msg_data, msg_size);
          size_d  = msg_size[1:0];
          last_d  = msg_last;
          pad_d   = msg_last && (msg_size == 3'd4);
          state_d = S_ABS_BLK_ISSUE;
        end
      end
      S_ABS_BLK_ISSUE: begin
        if (core_free) begin
          core_start_operation = 1'b1;
          state_d              = S_ABS_BLK_WAIT;
        end
      end
      S_ABS_BLK_WAIT: begin
        if (core_finish) begin
          op_d    = OP_PART;
          buf_d   = PAD_WORD;
          size_d  = 2'd0;
          state_d = S_ABS_EMPTY_ISSUE;
        end
      end
      S_ABS_EMPTY_ISSUE: begin
        if (core_free) begin
          core_start_operation = 1'b1;
          state_d              = S_ABS_EMPTY_WAIT;
        end
      end
      S_ABS_EMPTY_WAIT: begin
        // A full final word still owes the core a separate padding block.
        if (core_finish) begin
          op_d   = OP_PART;
          buf_d  = PAD_WORD;
          size_d = 2'd0;
          if (pad_q) begin
            pad_d   = 1'b0;
            state_d = S_ABS_BLK_ISSUE;
          end else if (last_q) begin
            cnt_d   = 8'd0;
            state_d = S_BLANK_ISSUE;
          end else begin
            state_d = S_ABS_WAIT;
          end
        end
      end
      S_BLANK_ISSUE: begin
        if (core_free) begin
          core_start_operation = 1'b1;
          state_d              = S_BLANK_WAIT;
        end
      end
      S_BLANK_WAIT: begin
        if (core_finish) begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = 8'd0;
            op_d    = OP_SQZ;
            buf_d   = PAD_WORD;
            size_d  = 2'd0;
            state_d = S_SQZ_ISSUE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_BLANK_ISSUE;
          end
        end
      end
      S_SQZ_ISSUE: begin
        if (core_free) begin
          core_start_operation = 1'b1;
          state_d              = S_SQZ_WAIT;
        end
      end
      S_SQZ_WAIT: begin
        if (core_finish) begin
          dig_data_d = core_buffer_out;
          dig_last_d = (cnt_q == DIG_LAST);
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (dig_ready) begin
          if (dig_last_q) begin
            op_d    = 4'd0;
            buf_d   = 32'h0;
            size_d  = 2'd0;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_SQZ_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      op_q       <= 4'd0;
      buf_q      <= 32'h0;
      size_q     <= 2'd0;
      last_q     <= 1'b0;
      pad_q      <= 1'b0;
      cnt_q      <= 8'd0;
      dig_data_q <= 32'h0;
      dig_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      buf_q      <= buf_d;
      size_q     <= size_d;
      last_q     <= last_d;
      pad_q      <= pad_d;
      cnt_q      <= cnt_d;
      dig_data_q <= dig_data_d;
      dig_last_q <= dig_last_d;
    end
  end

  assign busy                = (state_q != S_IDLE);
  assign dig_valid           = (state_q == S_OUT);
  assign dig_data            = dig_data_q;
  assign dig_last            = dig_last_q;
  assign core_operation_type = op_q;
  assign core_buffer_in      = buf_q;
  assign core_buffer_in_size = size_q;

`ifdef SUBTERRANEAN_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cycles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      perf_cnt_q    <= 32'h0;
      perf_cycles_q <= 32'h0;
    end else begin
      if (state_q == S_IDLE && state_d == S_INIT_ISSUE) perf_cnt_q <= 32'h0;
      else if (busy)                                     perf_cnt_q <= sat_inc(perf_cnt_q);
      if (state_q == S_OUT && dig_ready && dig_last_q)   perf_cycles_q <= perf_cnt_q;
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_subterranean_hash_sequencer.sv
// Directed bench for subterranean_hash_sequencer with a small mock duplex core that logs every command.
module tb_subterranean_hash_sequencer;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        msg_valid, msg_ready, msg_last;
  logic [31:0] msg_data;
  logic [2:0]  msg_size;
  logic        dig_valid, dig_ready, dig_last, busy;
  logic [31:0] dig_data;
  logic        core_start_operation, core_finish;
  logic [3:0]  core_operation_type;
  logic [31:0] core_buffer_in, core_buffer_out;
  logic [1:0]  core_buffer_in_size;
  logic        mock_free, free_block;
  wire         core_free = mock_free & ~free_block;
`ifdef SUBTERRANEAN_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int proto_err = 0;
  int base;

  logic [3:0]  log_op[$];
  logic [31:0] log_buf[$];
  logic [1:0]  log_size[$];
  logic [3:0]  exp_op[$];
  logic [31:0] exp_buf[$];
  logic [1:0]  exp_size[$];

  subterranean_hash_sequencer #(.DIGEST_WORDS(8), .BLANK_ROUNDS(8)) dut (
    .clk(clk), .arstn(arstn),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_size(msg_size),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .dig_last(dig_last), .busy(busy),
    .core_start_operation(core_start_operation), .core_operation_type(core_operation_type),
    .core_buffer_in(core_buffer_in), .core_buffer_in_size(core_buffer_in_size),
    .core_buffer_out(core_buffer_out), .core_free(core_free), .core_finish(core_finish)
`ifdef SUBTERRANEAN_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // Stand-in core state: rotate-xor accumulator, reset by init, returned by squeeze.
  function automatic logic [31:0] mix(input logic [31:0] a, input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd0) return 32'h0;
    return {a[26:0], a[31:27]} ^ b ^ {28'h0, op};
  endfunction

  logic [31:0] acc;
  int          remain;
  logic        prev_start;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mock_free       <= 1'b1;
      core_finish     <= 1'b0;
      core_buffer_out <= 32'h0;
      remain          <= 0;
      prev_start      <= 1'b0;
      acc = 32'h0;
    end else begin
      core_finish <= 1'b0;
      prev_start  <= core_start_operation;
      if (core_start_operation) begin
        if (!core_free || core_finish || prev_start || remain != 0) proto_err <= proto_err + 1;
        log_op.push_back(core_operation_type);
        log_buf.push_back(core_buffer_in);
        log_size.push_back(core_buffer_in_size);
        acc = mix(acc, core_operation_type, core_buffer_in);
        mock_free <= 1'b0;
        remain    <= 2;
      end else if (remain > 0) begin
        if (core_operation_type != log_op[log_op.size()-1] ||
            core_buffer_in != log_buf[log_buf.size()-1] ||
            core_buffer_in_size != log_size[log_size.size()-1]) proto_err <= proto_err + 1;
        if (remain == 1) begin
          core_finish     <= 1'b1;
          mock_free       <= 1'b1;
          core_buffer_out <= acc;
        end
        remain <= remain - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
    chk({tag, "_dig_valid"}, 32'(dig_valid), 32'd0);
    chk({tag, "_dig_data"}, dig_data, 32'd0);
    chk({tag, "_dig_last"}, 32'(dig_last), 32'd0);
    chk({tag, "_start"}, 32'(core_start_operation), 32'd0);
    chk({tag, "_op"}, 32'(core_operation_type), 32'd0);
    chk({tag, "_buf"}, core_buffer_in, 32'd0);
    chk({tag, "_size"}, 32'(core_buffer_in_size), 32'd0);
  endtask

  task automatic exp_push(input logic [3:0] op, input logic [31:0] b, input logic [1:0] s);
    exp_op.push_back(op);
    exp_buf.push_back(b);
    exp_size.push_back(s);
  endtask

  task automatic exp_start();
    exp_op.delete();
    exp_buf.delete();
    exp_size.delete();
    exp_push(4'd0, 32'h0, 2'd0);
  endtask

  task automatic exp_tail();
    for (int i = 0; i < 8; i++) exp_push(4'd2, 32'h1, 2'd0);
    for (int i = 0; i < 8; i++) exp_push(4'd7, 32'h1, 2'd0);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] s, input logic l);
    int t;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_size  = s;
    msg_last  = l;
    t = 0;
    while (!msg_ready && t < 300) begin
      tick();
      t++;
    end
    chk("msg_handshake_in_time", 32'(t < 300), 32'd1);
    tick();
  endtask

  task automatic recv_digest(input int stall);
    logic [31:0] a;
    logic [31:0] dexp[$];
    logic [31:0] d0;
    int          n0, t;
    a = 32'h0;
    for (int i = 0; i < exp_op.size(); i++) begin
      a = mix(a, exp_op[i], exp_buf[i]);
      if (exp_op[i] == 4'd7) dexp.push_back(a);
    end
    for (int k = 0; k < dexp.size(); k++) begin
      t = 0;
      while (!dig_valid && t < 300) begin
        tick();
        t++;
      end
      chk($sformatf("dig_valid_in_time[%0d]", k), 32'(t < 300), 32'd1);
      chk($sformatf("dig_data[%0d]", k), dig_data, dexp[k]);
      chk($sformatf("dig_last[%0d]", k), 32'(dig_last), 32'(k == dexp.size() - 1));
      if (k == stall) begin
        d0 = dig_data;
        n0 = log_op.size();
        for (int c = 0; c < 20; c++) begin
          tick();
          chk("stall_valid", 32'(dig_valid), 32'd1);
          chk("stall_data", dig_data, d0);
          chk("stall_last", 32'(dig_last), 32'd0);
        end
        chk("stall_no_new_cmd", 32'(log_op.size()), 32'(n0));
      end
      dig_ready = 1'b1;
      tick();
      dig_ready = 1'b0;
    end
    chk("busy_after_digest", 32'(busy), 32'd0);
  endtask

  task automatic check_trace(input string tag, input int b);
    int n;
    n = log_op.size() - b;
    chk({tag, "_cmd_count"}, 32'(n), 32'(exp_op.size()));
    for (int i = 0; i < n && i < exp_op.size(); i++) begin
      chk($sformatf("%s_op[%0d]", tag, i), 32'(log_op[b+i]), 32'(exp_op[i]));
      if (exp_op[i] != 4'd0) begin
        chk($sformatf("%s_buf[%0d]", tag, i), log_buf[b+i], exp_buf[i]);
        chk($sformatf("%s_size[%0d]", tag, i), 32'(log_size[b+i]), 32'(exp_size[i]));
      end
    end
    chk({tag, "_protocol"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    int t;
    msg_valid  = 1'b0;
    msg_data   = 32'h0;
    msg_size   = 3'd0;
    msg_last   = 1'b0;
    dig_ready  = 1'b0;
    free_block = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    arstn = 1'b1;
    tick();

    // Empty message: data must be ignored, pad word 1 absorbed.
    base = log_op.size();
    exp_start();
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_tail();
    send_word(32'hDEADBEEF, 3'd0, 1'b1);
    msg_valid = 1'b0;
    recv_digest(-1);
    check_trace("empty", base);

    // "abcd": full last word followed by an extra pad block.
    base = log_op.size();
    exp_start();
    exp_push(4'd1, 32'h64636261, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_tail();
    send_word(32'h64636261, 3'd4, 1'b1);
    msg_valid = 1'b0;
    recv_digest(-1);
    check_trace("abcd", base);

    // Core busy for 5 cycles, two-word message with partial tail, stalled digest word 3.
    base = log_op.size();
    exp_start();
    exp_push(4'd1, 32'h04030201, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h01636261, 2'd3);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_tail();
    free_block = 1'b1;
    msg_valid  = 1'b1;
    msg_data   = 32'h04030201;
    msg_size   = 3'd4;
    msg_last   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("blocked_no_start", 32'(core_start_operation), 32'd0);
    end
    chk("blocked_busy", 32'(busy), 32'd1);
    chk("blocked_no_cmd", 32'(log_op.size()), 32'(base));
    free_block = 1'b0;
    send_word(32'h04030201, 3'd4, 1'b0);
    send_word(32'hFF636261, 3'd3, 1'b1);
    msg_valid = 1'b0;
    recv_digest(3);
    check_trace("partial", base);

    // Reset in the middle of the blank rounds.
    base = log_op.size();
    send_word(32'h0, 3'd0, 1'b1);
    msg_valid = 1'b0;
    t = 0;
    while ((log_op.size() - base) < 5 && t < 300) begin
      tick();
      t++;
    end
    chk("reach_blank", 32'(t < 300), 32'd1);
    chk("in_blank_op", 32'(core_operation_type), 32'd2);
    arstn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick();
    arstn = 1'b1;
    tick();
    check_idle_outputs("after_reset");

    base = log_op.size();
    exp_start();
    exp_push(4'd1, 32'h64636261, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_push(4'd2, 32'h1, 2'd0);
    exp_tail();
    send_word(32'h64636261, 3'd4, 1'b1);
    msg_valid = 1'b0;
    recv_digest(-1);
    check_trace("post_reset", base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subterranean_hash_sequencer.md
Name: subterranean_hash_sequencer

Overview:
- Command initiator for the Subterranean duplex core. It drives the core's start/operation_type/buffer_in/buffer_in_size interface and consumes buffer_out/core_free/core_finish.
- Accepts a 32-bit little-endian message stream and issues the full unkeyed hash command sequence: initialize, absorb, blank rounds, squeeze.
- Returns the digest as a 32-bit word stream.
- Sits between the SoC-side stream fabric and the duplex core, replacing software sequencing.

Parameters:
- DIGEST_WORDS, 8, number of 32-bit squeeze words returned (8 = 256-bit digest); legal range 1..255.
- BLANK_ROUNDS, 8, number of empty duplex calls between absorb and squeeze; legal range 1..255.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- msg_valid  in  1  message word valid
- msg_ready  out  1  message word accepted when msg_valid & msg_ready
- msg_data  in  32  message bytes, byte0 in bits[7:0]
- msg_last  in  1  final message word
- msg_size  in  3  valid bytes in the word, 0..4; must be 4 unless msg_last; 0 only with msg_last (empty message)
- dig_valid  out  1  digest word valid
- dig_ready  in  1  digest consumer ready
- dig_data  out  32  digest word
- dig_last  out  1  final digest word
- busy  out  1  hash in progress
- core_start_operation  out  1  one-cycle command strobe to the core
- core_operation_type  out  4  0=init, 1=duplex full, 2=duplex incomplete, 7=squeeze
- core_buffer_in  out  32  padded block to the core
- core_buffer_in_size  out  2  msg_size mod 4
- core_buffer_out  in  32  core output register
- core_free  in  1  core idle, accepts a command
- core_finish  in  1  core completed the previous command

Behaviour:
- Reset values: all outputs 0. State = IDLE, counters = 0. A reset mid-hash aborts immediately with no digest.
- Command issue rule: assert core_start_operation for exactly one cycle, only when core_free=1. Then state WAIT holds all core_* outputs stable until core_finish=1. Never issue on the same cycle as that finish.
- Padding: a full block (size 4) uses op 1 with buffer_in = msg_data. An incomplete block of n bytes (0..3) uses op 2 with buffer_in[8n-1:0] = data, bit 8n = 1, and all higher bits 0. Data bits above 8n are ignored. An empty duplex is op 2, buffer_in = 32'h00000001, size 0.
- FSM states: IDLE, INIT, ABS_WAIT, ABS_BLK, ABS_EMPTY, BLANK, SQZ, OUT, each ISSUE/WAIT paired.
  - IDLE: on msg_valid, go to INIT. msg_ready stays 0.
  - INIT: issue op 0, then go to ABS_WAIT.
  - ABS_WAIT: msg_ready=1 for the one cycle when the core is free. Capture the word, go to ABS_BLK. Do not accept a beat while a command is outstanding.
  - ABS_BLK: issue the captured block (op 1 or op 2), then go to ABS_EMPTY.
  - ABS_EMPTY: issue an empty duplex. Next state is BLANK if the captured word had msg_last, else ABS_WAIT.
  - A msg_last word with size 4 is followed by an extra padded block: op 2, 32'h1, size 0, then an empty duplex.
  - BLANK: issue BLANK_ROUNDS empty duplexes, counted 0..BLANK_ROUNDS-1.
  - SQZ: issue op 7 with buffer_in 32'h1, size 0. After core_finish, latch core_buffer_out into dig_data and go to OUT.
  - OUT: hold dig_valid until dig_ready. dig_last = (word index == DIGEST_WORDS-1). After the handshake, go back to SQZ if words remain, else IDLE.
- dig_data and dig_last stay stable while dig_valid & !dig_ready.
- busy = (state != IDLE).
- A msg_valid held across the hash boundary starts the next hash only after returning to IDLE.
- Command count per hash: 1 + 2*(number of absorbed blocks incl. pad block) + BLANK_ROUNDS + DIGEST_WORDS.

Optional Feature:
- Macro SUBTERRANEAN_SEQ_PERF_CNT_EN. When defined, add output perf_cycles[31:0]. An internal counter clears on IDLE->INIT, increments every cycle while busy, saturates at 32'hFFFFFFFF, and is copied to perf_cycles on the final dig handshake. perf_cycles resets to 0.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Empty message (one beat, msg_last=1, size 0). Command trace is op0, op2/32'h1, op2/32'h1, 8x op2/32'h1, 8x op7/32'h1 (19 commands). dig_last only on the 8th word.
- One word 32'h64636261, size 4, last. Trace is op0, op1/32'h64636261, op2/32'h1, op2/32'h1, op2/32'h1, then 8 blank rounds and 8 squeezes. Digest matches the software model for "abcd".
- Last word size 3, data 32'hFF636261. Core sees op2, buffer_in 32'h01636261, size 2'b11.
- dig_ready held 0 for 20 cycles on word 3. dig_data stays stable and no further op7 is issued until the handshake.
- Core mock holding core_free=0 for 5 cycles. No core_start_operation during that time, and every command strobe is exactly 1 cycle wide.
- arstn pulsed low during BLANK. All outputs return to 0, and the next message produces a correct digest starting from op0.
